// File: rtl/cache_req_arbiter.sv
// Two-requester round-robin front end for a single-outstanding cache controller port.
// Grants one request, issues it once the cache is ready, waits (with timeout) and returns one response.
module cache_req_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  r0_req_valid,
   input  logic [1:0]            r0_req_op,
   input  logic [ADDR_WIDTH-1:0] r0_req_addr,
   input  logic [DATA_WIDTH-1:0] r0_req_wdata,
   output logic                  r0_req_ready,
   output logic                  r0_rsp_valid,
   output logic                  r0_rsp_err,
   output logic [DATA_WIDTH-1:0] r0_rsp_rdata,
   input  logic                  r1_req_valid,
   input  logic [1:0]            r1_req_op,
   input  logic [ADDR_WIDTH-1:0] r1_req_addr,
   input  logic [DATA_WIDTH-1:0] r1_req_wdata,
   output logic                  r1_req_ready,
   output logic                  r1_rsp_valid,
   output logic                  r1_rsp_err,
   output logic [DATA_WIDTH-1:0] r1_rsp_rdata,
   output logic [1:0]            cpu_request,
   output logic [ADDR_WIDTH-1:0] cpu_addr,
   output logic [DATA_WIDTH-1:0] cpu_wdata,
   input  logic                  cache_ready,
   input  logic                  cache_complete,
   input  logic [DATA_WIDTH-1:0] cache_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

   localparam logic [1:0] OP_READ    = 2'b00;
   localparam logic [1:0] OP_ILLEGAL = 2'b10;
   localparam logic [1:0] OP_NONE    = 2'b11;
   localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

   state_t                r_state, w_next;
   logic                  r_last;
   logic                  r_owner;
   logic [1:0]            r_op;
   logic [7:0]            r_cnt;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;

   logic                  w_elig0, w_elig1, w_gnt, w_gnt_id, w_timeout, w_rsp;
   logic [1:0]            w_gnt_op;
   logic [ADDR_WIDTH-1:0] w_gnt_addr;
   logic [DATA_WIDTH-1:0] w_gnt_wdata;

   assign w_elig0     = r0_req_valid && (r0_req_op != OP_NONE);
   assign w_elig1     = r1_req_valid && (r1_req_op != OP_NONE);
   // ready is combinational from the inputs, so keep it quiet while reset is held
   assign w_gnt       = reset && (r_state == S_IDLE) && (w_elig0 || w_elig1);
   assign w_gnt_id    = (w_elig0 && w_elig1) ? ~r_last : w_elig1;
   assign w_gnt_op    = w_gnt_id ? r1_req_op    : r0_req_op;
   assign w_gnt_addr  = w_gnt_id ? r1_req_addr  : r0_req_addr;
   assign w_gnt_wdata = w_gnt_id ? r1_req_wdata : r0_req_wdata;
   assign w_timeout   = (r_cnt == CNT_LAST);
   assign w_rsp       = (r_state == S_RESPOND);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_gnt) w_next = (w_gnt_op == OP_ILLEGAL) ? S_RESPOND : S_ISSUE;
         S_ISSUE:   if (cache_ready) w_next = S_WAIT;
         S_WAIT:    if (cache_complete || w_timeout) w_next = S_RESPOND;
         S_RESPOND: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_last  <= 1'b1;
         r_owner <= 1'b0;
         r_op    <= OP_NONE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_rdata <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (r_state == S_WAIT && !cache_complete) ? r_cnt + 8'd1 : 8'd0;
         case (r_state)
            S_IDLE: if (w_gnt) begin
               r_owner <= w_gnt_id;
               r_op    <= w_gnt_op;
               r_addr  <= w_gnt_addr;
               r_wdata <= w_gnt_wdata;
               r_err   <= (w_gnt_op == OP_ILLEGAL);
               r_rdata <= '0;
            end
            // completion takes priority over a timeout landing on the same cycle
            S_WAIT: if (cache_complete) begin
               r_err   <= 1'b0;
               r_rdata <= (r_op == OP_READ) ? cache_rdata : '0;
            end else if (w_timeout) begin
               r_err   <= 1'b1;
               r_rdata <= '0;
            end
            S_RESPOND: r_last <= r_owner;
            default: ;
         endcase
      end
   end

   assign r0_req_ready = w_gnt && !w_gnt_id;
   assign r1_req_ready = w_gnt &&  w_gnt_id;
   assign r0_rsp_valid = w_rsp && !r_owner;
   assign r1_rsp_valid = w_rsp &&  r_owner;
   assign r0_rsp_err   = r0_rsp_valid && r_err;
   assign r1_rsp_err   = r1_rsp_valid && r_err;
   assign r0_rsp_rdata = r0_rsp_valid ? r_rdata : '0;
   assign r1_rsp_rdata = r1_rsp_valid ? r_rdata : '0;
   assign cpu_request  = (r_state == S_ISSUE && cache_ready) ? r_op : OP_NONE;
   assign cpu_addr     = r_addr;
   assign cpu_wdata    = r_wdata;

endmodule
